// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule FSM states and the round-constant table.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        SERVE
    } state_t;

    // Index 0 and 11..15 never select a real round; they return zero.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] value;
        value = 8'h00;
        case (idx)
            4'd1:    value = 8'h01;
            4'd2:    value = 8'h02;
            4'd3:    value = 8'h04;
            4'd4:    value = 8'h08;
            4'd5:    value = 8'h10;
            4'd6:    value = 8'h20;
            4'd7:    value = 8'h40;
            4'd8:    value = 8'h80;
            4'd9:    value = 8'h1b;
            4'd10:   value = 8'h36;
            default: value = 8'h00;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
module aes_sbox (
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);

    logic [127:0] row;

    // Upper nibble picks a 16-byte row, lower nibble picks the byte (byte 0 is the MSB end).
    always_comb begin
        row = '0;
        case (byte_in[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
            default: row = '0;
        endcase
    end

    assign byte_out = row[{~byte_in[3:0], 3'b000} +: 8];

endmodule

// File: rtl/inv_key_sched.sv
// AES-128 key schedule that expands forward to round 10, then walks back down to round 0 on request.
module inv_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         next,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    state_t       state;
    logic [127:0] key_reg;
    logic [3:0]   rcnt;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sbox_in, rot_word, sub_word, t_word;
    logic [7:0]   rc;
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] fwd_key, inv_key;

    assign {w0, w1, w2, w3} = key_reg;

    // The inverse step needs SubWord of the recovered w3, which is w3^w2 of the current key.
    assign sbox_in  = (state == SERVE) ? (w3 ^ w2) : w3;
    assign rot_word = {sbox_in[23:0], sbox_in[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_in  (rot_word[8*i +: 8]),
            .byte_out (sub_word[8*i +: 8])
        );
    end

    assign rc     = rcon((state == EXPAND) ? (rcnt + 4'd1) : rcnt);
    assign t_word = sub_word ^ {rc, 24'h000000};

    assign f0      = w0 ^ t_word;
    assign f1      = w1 ^ f0;
    assign f2      = w2 ^ f1;
    assign f3      = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};
    assign inv_key = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    assign round_key = key_reg;
    assign round_num = rcnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            key_reg   <= '0;
            rcnt      <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state     <= EXPAND;
                key_reg   <= key_in;
                rcnt      <= '0;
                key_valid <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    EXPAND: begin
                        key_reg <= fwd_key;
                        rcnt    <= rcnt + 4'd1;
                        if (rcnt == 4'd9) begin
                            state     <= SERVE;
                            busy      <= 1'b0;
                            key_valid <= 1'b1;
                        end
                    end
                    SERVE: begin
                        if (next) begin
                            if (rcnt != 4'd0) begin
                                key_reg <= inv_key;
                                rcnt    <= rcnt - 4'd1;
                            end else begin
                                state     <= IDLE;
                                key_valid <= 1'b0;
                                done      <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
